// File: rtl/edge_mon_pkg.sv
// rtl/edge_mon_pkg.sv - shared types and helpers for the edge event monitor
package edge_mon_pkg;

  // Which detected edges are queued as events
  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_POS  = 2'b01,
    SEL_NEG  = 2'b10,
    SEL_BOTH = 2'b11
  } edge_sel_e;

  // Widest timestamp any instance may use; narrower TS_W values are zero-extended
  localparam int TS_MAX_W = 32;

  typedef struct packed {
    logic                rising;
    logic [TS_MAX_W-1:0] ts;
  } edge_evt_t;

  // True when a detected edge is one the selector asks to keep
  function automatic logic sel_match(edge_sel_e sel, logic rise, logic fall);
    logic m;
    case (sel)
      SEL_POS:  m = rise;
      SEL_NEG:  m = fall;
      SEL_BOTH: m = rise | fall;
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/edge_event_monitor_if.sv
// rtl/edge_event_monitor_if.sv - event stream handshake between monitor and consumer
// Signals: evt_valid (head present), evt_ready (consumer accepts head),
//          evt_ts (head timestamp), evt_rising (head polarity, 1 = rising).
// master: the monitor driving events; slave: the consumer.
interface edge_event_monitor_if #(
  parameter int TS_W = 16
);
  logic            evt_valid;
  logic            evt_ready;
  logic [TS_W-1:0] evt_ts;
  logic            evt_rising;

  modport master (output evt_valid, output evt_ts, output evt_rising, input evt_ready);
  modport slave  (input evt_valid, input evt_ts, input evt_rising, output evt_ready);
endinterface

// File: rtl/edge_event_fifo.sv
// rtl/edge_event_fifo.sv - small synchronous FIFO holding queued edge events
// Ports: clk, rst (async, active high); push/push_data write the tail when room
// (or when a pop frees a slot the same cycle); pop removes the head when non-empty;
// full/empty status; pop_data shows the head entry.
module edge_event_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is only observed while non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/edge_event_monitor.sv
// rtl/edge_event_monitor.sv - synchronizes a signal, strobes its edges and queues timestamped events
// Ports: clk, rst (async, active high); sig_in asynchronous input; edge_sel picks
// queued edges; pos_pulse/neg_pulse/any_pulse one-cycle edge strobes; evt event
// stream (master side); overflow sticky drop flag, cleared by clr_overflow.
module edge_event_monitor
  import edge_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  edge_sel_e            edge_sel,
  output logic                 pos_pulse,
  output logic                 neg_pulse,
  output logic                 any_pulse,
  edge_event_monitor_if.master evt,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  logic [SYNC_STAGES-1:0] sync_q;
  // Tracks which sync stages hold real samples rather than reset zeros
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   primed_q;
  logic                   pos_q, neg_q;
  logic                   overflow_q, overflow_d;
  logic [TS_W-1:0]        ts_q;

  logic                   rise_d, fall_d;
  logic                   push_req, pop;
  logic                   fifo_full, fifo_empty;
  edge_evt_t              evt_d, head;

  // prev only compares against the sync output once it holds a real sample,
  // so a high input at reset release is not mistaken for a rising edge
  assign rise_d = primed_q &&  sync_q[SYNC_STAGES-1] && !prev_q;
  assign fall_d = primed_q && !sync_q[SYNC_STAGES-1] &&  prev_q;

  assign push_req = sel_match(edge_sel, rise_d, fall_d);
  assign pop      = evt.evt_ready && !fifo_empty;

  always_comb begin
    evt_d        = '0;
    evt_d.rising = rise_d;
    evt_d.ts     = TS_MAX_W'(ts_q);
  end

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
    else if (clr_overflow)             overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      vld_q      <= '0;
      prev_q     <= 1'b0;
      primed_q   <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      primed_q   <= vld_q[SYNC_STAGES-1];
      pos_q      <= rise_d;
      neg_q      <= fall_d;
      ts_q       <= ts_q + 1'b1;
      overflow_q <= overflow_d;
    end
  end

  edge_event_fifo #(
    .WIDTH($bits(edge_evt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_data(evt_d),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .pop_data (head)
  );

  assign pos_pulse      = pos_q;
  assign neg_pulse      = neg_q;
  assign any_pulse      = pos_q | neg_q;
  assign overflow       = overflow_q;
  // Head fields are forced to zero while empty so reset and idle read 0
  assign evt.evt_valid  = !fifo_empty;
  assign evt.evt_ts     = fifo_empty ? '0 : TS_W'(head.ts);
  assign evt.evt_rising = !fifo_empty && head.rising;
endmodule

// File: tb/tb_edge_event_monitor.sv
// tb/tb_edge_event_monitor.sv - self-checking bench for edge_event_monitor
module tb_edge_event_monitor;
  import edge_mon_pkg::*;

  localparam int S     = 2;
  localparam int TW    = 4;
  localparam int D     = 4;
  localparam int TMASK = (1 << TW) - 1;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      sig_in = 1'b0;
  logic      clr_overflow = 1'b0;
  edge_sel_e edge_sel = SEL_NONE;
  logic      pos_pulse, neg_pulse, any_pulse, overflow;

  edge_event_monitor_if #(.TS_W(TW)) evt_if ();

  edge_event_monitor #(.SYNC_STAGES(S), .TS_W(TW), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .edge_sel    (edge_sel),
    .pos_pulse   (pos_pulse),
    .neg_pulse   (neg_pulse),
    .any_pulse   (any_pulse),
    .evt         (evt_if),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { bit rising; int ts; } ev_t;
  typedef struct { edge_sel_e sel; bit rising; bit exp_push; } vec_t;

  ev_t mq[$];
  ev_t got[$];
  bit  hist[$];
  int  exp_ts[$];
  bit  m_pos, m_neg, m_ov;
  int  n_tests = 0;
  int  n_fail = 0;
  int  pulse_cnt = 0;
  int  last_k = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a transition seen between samples N-1 and N strobes at edge N+S;
  // the timestamp is the edge index since release modulo 2^TW.
  always @(posedge clk) begin
    int k;
    bit a, b, push, pop, set;
    logic [TW+5:0] exp_v, act_v;
    if (rst) begin
      hist.delete(); mq.delete();
      m_pos = 0; m_neg = 0; m_ov = 0; last_k = -1;
    end else begin
      k = hist.size();
      hist.push_back(sig_in);
      last_k = k;
      m_pos = 0; m_neg = 0;
      if (k >= S + 1) begin
        a = hist[k-S]; b = hist[k-S-1];
        m_pos = a & ~b; m_neg = ~a & b;
      end
      pop  = (mq.size() > 0) && evt_if.evt_ready;
      push = (m_pos && (edge_sel == SEL_POS || edge_sel == SEL_BOTH)) ||
             (m_neg && (edge_sel == SEL_NEG || edge_sel == SEL_BOTH));
      set = 0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < D) mq.push_back('{m_pos, k & TMASK});
        else set = 1;
      end
      if (set) m_ov = 1;
      else if (clr_overflow) m_ov = 0;
    end
    #1;
    exp_v = {m_pos, m_neg, m_pos | m_neg, mq.size() > 0,
             (mq.size() > 0) ? mq[0].rising : 1'b0, m_ov,
             (mq.size() > 0) ? TW'(mq[0].ts) : TW'(0)};
    act_v = {pos_pulse, neg_pulse, any_pulse, evt_if.evt_valid,
             evt_if.evt_rising, overflow, evt_if.evt_ts};
    chk($sformatf("cyc%0d_outputs", last_k), int'(act_v), int'(exp_v));
    if (pos_pulse || neg_pulse) pulse_cnt++;
  end

  // Capture accepted entries just before the edge that pops them
  always @(negedge clk) begin
    #4;
    if (!rst && evt_if.evt_valid && evt_if.evt_ready)
      got.push_back('{evt_if.evt_rising, int'(evt_if.evt_ts)});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    pulse_cnt = 0;
    got.delete();
    cycles(S + 3);
  endtask

  task automatic rise_fall();
    sig_in = 1'b1; cycles(S + 3);
    sig_in = 1'b0; cycles(S + 3);
  endtask

  initial begin
    vec_t tbl[8];
    int n;
    int new_ts;
    tbl = '{'{SEL_NONE, 1, 0}, '{SEL_NONE, 0, 0}, '{SEL_POS, 1, 1}, '{SEL_POS, 0, 0},
            '{SEL_NEG, 1, 0},  '{SEL_NEG, 0, 1},  '{SEL_BOTH, 1, 1}, '{SEL_BOTH, 0, 1}};
    evt_if.evt_ready = 1'b0;

    // High input at reset release must not look like an edge
    sig_in = 1'b1;
    cycles(2);
    rst = 1'b0;
    pulse_cnt = 0;
    cycles(20);
    chk("no_spurious_pulse", pulse_cnt, 0);
    chk("no_spurious_valid", evt_if.evt_valid, 0);

    // Edge selector decode
    for (int i = 0; i < 8; i++) begin
      if (sig_in == tbl[i].rising) begin
        edge_sel = SEL_NONE; sig_in = ~sig_in; cycles(S + 3);
      end
      edge_sel = tbl[i].sel;
      sig_in = tbl[i].rising;
      cycles(S + 1);
      chk($sformatf("tbl%0d_valid", i), evt_if.evt_valid, tbl[i].exp_push);
      if (tbl[i].exp_push) chk($sformatf("tbl%0d_rising", i), evt_if.evt_rising, tbl[i].rising);
      edge_sel = SEL_NONE;
      evt_if.evt_ready = 1'b1; cycles(2); evt_if.evt_ready = 1'b0;
    end

    // BOTH edges, toggling every 10 cycles, always ready
    sig_in = 1'b0; do_reset();
    edge_sel = SEL_BOTH; evt_if.evt_ready = 1'b1; got.delete();
    for (int i = 0; i < 6; i++) begin
      n = 0;
      sig_in = ~sig_in;
      while (n < 10) begin
        cycles(1); n++;
        if (any_pulse) break;
      end
      chk("latency", n, S + 1);
      cycles(10 - n);
    end
    cycles(3);
    chk("both_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) begin
      chk("both_polarity", got[i].rising, (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("both_ts_delta", (got[i].ts - got[i-1].ts) & TMASK, 10);
    end
    evt_if.evt_ready = 1'b0;

    // Overflow: six rising edges into a four-entry FIFO
    sig_in = 1'b0; do_reset();
    edge_sel = SEL_POS; exp_ts.delete();
    for (int i = 0; i < 6; i++) begin
      sig_in = 1'b1; cycles(S + 1);
      exp_ts.push_back(last_k & TMASK);
      cycles(2);
      sig_in = 1'b0; cycles(4);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", evt_if.evt_valid, 1);
    clr_overflow = 1'b1; cycles(1); clr_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    got.delete();
    evt_if.evt_ready = 1'b1; cycles(8); evt_ready_off();
    chk("ovf_kept", got.size(), D);
    for (int i = 0; i < got.size() && i < D; i++) chk($sformatf("ovf_ts%0d", i), got[i].ts, exp_ts[i]);

    // Full FIFO: pop and push on the same edge
    sig_in = 1'b0; do_reset();
    edge_sel = SEL_POS;
    for (int i = 0; i < D; i++) rise_fall();
    got.delete();
    sig_in = 1'b1; cycles(S);
    evt_if.evt_ready = 1'b1; cycles(1); evt_if.evt_ready = 1'b0;
    new_ts = last_k & TMASK;
    chk("full_pop_once", got.size(), 1);
    chk("full_no_ovf", overflow, 0);
    got.delete();
    evt_if.evt_ready = 1'b1; cycles(8); evt_if.evt_ready = 1'b0;
    chk("full_occupancy", got.size(), D);
    if (got.size() >= D) chk("full_tail_ts", got[D-1].ts, new_ts);

    // Timestamp wrap: edges at counter 14 and 18
    sig_in = 1'b0; do_reset();
    edge_sel = SEL_BOTH;
    n = 0;
    while ((((last_k + 1 + S) & TMASK) != 14) && n < 40) begin cycles(1); n++; end
    sig_in = 1'b1; cycles(4);
    sig_in = 1'b0; cycles(S + 2);
    chk("wrap_ts0", evt_if.evt_ts, 14);
    chk("wrap_pol0", evt_if.evt_rising, 1);
    evt_if.evt_ready = 1'b1; cycles(1); evt_if.evt_ready = 1'b0;
    chk("wrap_ts1", evt_if.evt_ts, 2);
    chk("wrap_pol1", evt_if.evt_rising, 0);

    // Reset with entries queued and an edge still in the synchronizer
    sig_in = 1'b0; do_reset();
    edge_sel = SEL_POS;
    for (int i = 0; i < 3; i++) rise_fall();
    chk("pre_rst_valid", evt_if.evt_valid, 1);
    sig_in = 1'b1; cycles(1);
    rst = 1'b1; cycles(2); rst = 1'b0;
    pulse_cnt = 0;
    cycles(12);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_no_pulse", pulse_cnt, 0);

    // Randomized traffic checked cycle by cycle against the reference
    sig_in = 1'b0; do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      sig_in = 1'($urandom_range(0, 1));
      edge_sel = edge_sel_e'($urandom_range(0, 3));
      repeat ($urandom_range(1, 8)) begin
        evt_if.evt_ready = ($urandom_range(0, 9) < 4);
        clr_overflow = ($urandom_range(0, 19) == 0);
        cycles(1);
      end
    end
    evt_if.evt_ready = 1'b0; clr_overflow = 1'b0;
    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic evt_ready_off();
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
